// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, branch/jump resolution,
// PC redirect generation, misaligned-target detection and a taken-transfer counter.
module ex_mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic [DATA_WIDTH-1:0]     pc,
    input  logic [DATA_WIDTH-1:0]     imm,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic                      RegWrite,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      Branch,
    input  logic                      Jump,
    input  logic                      Jalr,
    input  logic [2:0]                funct3,
    input  logic                      flush,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     mem_addr_or_result,
    output logic [DATA_WIDTH-1:0]     store_data,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_RegWrite,
    output logic                      out_MemRead,
    output logic                      out_MemWrite,
    output logic [2:0]                out_funct3,
    output logic                      redirect,
    output logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic                      misaligned,
    output logic [31:0]               taken_count
);

    localparam logic [DATA_WIDTH-1:0] LSB_CLEAR = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

    logic                      accept;
    logic                      taken;
    logic                      bad_target;
    logic [DATA_WIDTH-1:0]     target;

    logic                      out_valid_q,    out_valid_d;
    logic [DATA_WIDTH-1:0]     result_q,       result_d;
    logic [DATA_WIDTH-1:0]     store_data_q,   store_data_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,           rd_d;
    logic                      reg_write_q,    reg_write_d;
    logic                      mem_read_q,     mem_read_d;
    logic                      mem_write_q,    mem_write_d;
    logic [2:0]                funct3_q,       funct3_d;
    logic                      redirect_q,     redirect_d;
    logic                      misaligned_q,   misaligned_d;
    logic [DATA_WIDTH-1:0]     redirect_pc_q,  redirect_pc_d;
    logic [31:0]               taken_count_q,  taken_count_d;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready && !flush;
    assign taken      = Jump || (Branch && ALUResult[0]);
    assign target     = Jalr ? ((rs1_data + imm) & LSB_CLEAR) : (pc + imm);
    assign bad_target = target[1];

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block leaves a signal unassigned (no latches).
        out_valid_d   = out_valid_q;
        result_d      = result_q;
        store_data_d  = store_data_q;
        rd_d          = rd_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        funct3_d      = funct3_q;
        redirect_pc_d = redirect_pc_q;
        taken_count_d = taken_count_q;
        redirect_d    = accept && taken && !bad_target;
        misaligned_d  = accept && taken && bad_target;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            result_d     = Jump ? (pc + DATA_WIDTH'(4)) : ALUResult;
            store_data_d = rs2_data;
            rd_d         = rd;
            funct3_d     = funct3;
            // A misaligned control transfer still advances, but as a side-effect-free bubble.
            reg_write_d  = RegWrite && (rd != '0) && !misaligned_d;
            mem_read_d   = MemRead && !misaligned_d;
            mem_write_d  = MemWrite && !misaligned_d;
        end

        if (redirect_d) begin
            redirect_pc_d = target;
            taken_count_d = taken_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            store_data_q  <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            funct3_q      <= '0;
            redirect_q    <= 1'b0;
            misaligned_q  <= 1'b0;
            redirect_pc_q <= '0;
            taken_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers sample pre-edge values together.
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            store_data_q  <= store_data_d;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            funct3_q      <= funct3_d;
            redirect_q    <= redirect_d;
            misaligned_q  <= misaligned_d;
            redirect_pc_q <= redirect_pc_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign mem_addr_or_result = result_q;
    assign store_data         = store_data_q;
    assign out_rd             = rd_q;
    assign out_RegWrite       = reg_write_q;
    assign out_MemRead        = mem_read_q;
    assign out_MemWrite       = mem_write_q;
    assign out_funct3         = funct3_q;
    assign redirect           = redirect_q;
    assign misaligned         = misaligned_q;
    assign redirect_pc        = redirect_pc_q;
    assign taken_count        = taken_count_q;

endmodule
